// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage program-counter generator.
package pc_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_HOLD,
        NPC_TRAP,
        NPC_REDIR,
        NPC_CALL,
        NPC_RET,
        NPC_CALLRET
    } npc_sel_t;

    localparam int DEF_XLEN      = 32;
    localparam int DEF_INC       = 4;
    localparam int DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry, and
// the top entry is readable in the same cycle so a return can use it at once.
module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       replace,
    input  logic [XLEN-1:0]            wdata,
    output logic [XLEN-1:0]            rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [PW-1:0]   top_idx;
    logic            wr_en;
    logic [PW-1:0]   wr_idx;
    logic            empty;

    // ptr_reg is the next free slot; the top of stack sits one entry behind it
    assign top_idx = ptr_reg - PW'(1);
    assign empty   = (count_reg == '0);

    always_comb begin
        wr_en  = !rst && !flush && (push || replace);
        wr_idx = (replace && !empty) ? top_idx : ptr_reg;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ptr_reg   <= '0;
            count_reg <= '0;
        end else if (replace) begin
            // replacing into an empty stack degenerates to a push
            if (empty) begin
                ptr_reg   <= ptr_reg + PW'(1);
                count_reg <= CW'(1);
            end
        end else if (push) begin
            ptr_reg <= ptr_reg + PW'(1);
            if (count_reg != CW'(DEPTH)) begin
                count_reg <= count_reg + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr_reg   <= top_idx;
            count_reg <= count_reg - CW'(1);
        end
    end

    assign rdata = mem[top_idx];
    assign count = count_reg;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: fixed-priority next-PC selection between trap,
// redirect, stall, call/return prediction and sequential fetch.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              INC       = DEF_INC,
    parameter int              RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         trap_en,
    input  logic [XLEN-1:0]              trap_pc,
    input  logic                         redirect_en,
    input  logic [XLEN-1:0]              redirect_pc,
    input  logic                         call_en,
    input  logic [XLEN-1:0]              call_target,
    input  logic                         ret_en,
    output logic [XLEN-1:0]              pc,
    output logic                         pc_valid,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_miss
);

    localparam int              CW         = $clog2(RAS_DEPTH) + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INC - 1);

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] ras_top;
    logic [CW-1:0]   ras_cnt;
    logic            valid_reg;
    logic            miss_reg;
    logic            miss_next;
    logic            ras_flush;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_replace;
    npc_sel_t        sel;

    // wraps modulo 2^XLEN by construction
    assign seq_pc = pc_reg + XLEN'(INC);

    always_comb begin
        sel       = NPC_SEQ;
        miss_next = 1'b0;
        if (trap_en) begin
            sel = NPC_TRAP;
        end else if (redirect_en) begin
            sel = NPC_REDIR;
        end else if (stall) begin
            sel = NPC_HOLD;
        end else if (call_en && ret_en) begin
            sel = NPC_CALLRET;
        end else if (call_en) begin
            sel = NPC_CALL;
        end else if (ret_en) begin
            if (ras_cnt != '0) begin
                sel = NPC_RET;
            end else begin
                miss_next = 1'b1;
            end
        end
    end

    always_comb begin
        pc_next     = seq_pc;
        ras_flush   = 1'b0;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_replace = 1'b0;
        case (sel)
            NPC_TRAP: begin
                pc_next   = trap_pc & ALIGN_MASK;
                ras_flush = 1'b1;
            end
            NPC_REDIR:   pc_next = redirect_pc & ALIGN_MASK;
            NPC_HOLD:    pc_next = pc_reg;
            NPC_CALLRET: begin
                pc_next     = call_target & ALIGN_MASK;
                ras_replace = 1'b1;
            end
            NPC_CALL: begin
                pc_next  = call_target & ALIGN_MASK;
                ras_push = 1'b1;
            end
            NPC_RET: begin
                pc_next = ras_top & ALIGN_MASK;
                ras_pop = 1'b1;
            end
            default:     pc_next = seq_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= RESET_VEC;
            valid_reg <= 1'b0;
            miss_reg  <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            valid_reg <= 1'b1;
            miss_reg  <= miss_next;
        end
    end

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .flush   (ras_flush),
        .push    (ras_push),
        .pop     (ras_pop),
        .replace (ras_replace),
        .wdata   (seq_pc),
        .rdata   (ras_top),
        .count   (ras_cnt)
    );

    assign pc        = pc_reg;
    assign pc_valid  = valid_reg;
    assign ras_count = ras_cnt;
    assign ras_miss  = miss_reg;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage; successor to the single-width PC register.
- Selects next PC per cycle from trap, datapath redirect, stall hold, call, return or sequential increment, under a fixed priority.
- Holds an internal circular return-address stack (RAS) for call/return target prediction.
- Drives the instruction ROM address and the PC operand to the ALU.

Parameters:
XLEN, 32, PC and target width in bits
RESET_VEC, 32'h0000_0000, PC value loaded by reset
INC, 4, sequential increment in bytes (power of two, >= 1)
RAS_DEPTH, 4, return-address stack entries (power of two, >= 2)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, synchronous, active-high
stall  in  1  hold PC (pipeline bubble)
trap_en  in  1  take trap/exception this cycle
trap_pc  in  XLEN  trap handler address
redirect_en  in  1  resolved branch/jump from datapath
redirect_pc  in  XLEN  redirect target
call_en  in  1  instruction at current PC is a call
call_target  in  XLEN  call destination
ret_en  in  1  instruction at current PC is a return
pc  out  XLEN  current program counter
pc_valid  out  1  pc holds a fetchable address
ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_miss  out  1  one-cycle pulse: return with RAS empty

Behaviour:
- Reset, clk edge with rst=1: pc=RESET_VEC, pc_valid=0, ras_count=0, ras_miss=0, RAS pointer=0. Entry contents are don't-care.
- First edge with rst=0: pc_valid=1. It stays 1 until the next reset.
- Next-PC selection applies on every edge with rst=0, in strict priority order:
  1. trap_en: pc=trap_pc. RAS flushed (ras_count=0, pointer=0).
  2. redirect_en: pc=redirect_pc. RAS untouched.
  3. stall: pc unchanged. No RAS activity, even if call_en or ret_en is high.
  4. call_en and ret_en together: pc=call_target. The top entry is overwritten with pc+INC. ras_count unchanged; if it was 0, push instead (count becomes 1).
  5. call_en: push pc+INC, then pc=call_target.
  6. ret_en with ras_count>0: pc=top entry, pop.
  7. ret_en with ras_count=0: pc=pc+INC, ras_miss=1 for that cycle.
  8. otherwise: pc=pc+INC.
- Lower-priority requests in the same cycle are discarded. Callers re-issue them if needed.
- Alignment: the log2(INC) LSBs of trap_pc, redirect_pc, call_target and RAS-sourced PCs are forced to 0 before loading.
- Arithmetic: pc+INC wraps modulo 2^XLEN (e.g. 32'hFFFF_FFFC+4 gives 0). No flag is raised.
- RAS is circular:
  - Push when full overwrites the oldest entry; ras_count saturates at RAS_DEPTH.
  - Pop decrements ras_count and moves the pointer back one entry.
- Latency: every output is registered. A request sampled at edge N is visible on pc at edge N.
- ras_miss is low in every cycle except case 7.
- Reset asserted mid-sequence overrides all requests in the same cycle.

Decomposition:
- Shared package pc_pkg:
  - enum npc_sel_t {NPC_SEQ, NPC_HOLD, NPC_TRAP, NPC_REDIR, NPC_CALL, NPC_RET, NPC_CALLRET}
  - default parameter constants (XLEN=32, INC=4).
- Sub-module pc_ras: circular stack.
  - Ports: clk, rst, flush, push, pop, replace, wdata, rdata, count.
  - pc_gen holds the select logic and the PC register.

Test Plan:
- Reset, then release rst for 3 cycles, no requests -> pc 0, 4, 8, 12; pc_valid 0 during reset, then 1.
- pc=0x10, call_en with call_target=0x100, 2 sequential cycles, then ret_en -> pc 0x100, 0x104, 0x108, 0x14; ras_count 1 then 0.
- 5 consecutive calls (RAS_DEPTH=4) from pc 0x0, 0x200, 0x300, 0x400, 0x500, then 5 returns:
  - ras_count saturates at 4; returns yield 0x504, 0x404, 0x304, 0x204;
  - 5th return gives pc+4 with ras_miss=1 for one cycle.
- trap_en, redirect_en, stall and call_en all high in one cycle (trap_pc=0x80, redirect_pc=0x40) -> pc=0x80, ras_count=0. Next cycle redirect_en with stall -> pc=0x40.
- stall with call_en high for 2 cycles at pc=0x20 -> pc holds 0x20, ras_count unchanged. redirect_pc=0x33 -> pc=0x30.
- pc=0xFFFF_FFFC with no requests -> pc=0x0000_0000. rst asserted during a call -> pc=RESET_VEC, ras_count=0.
